// File: rtl/mem_ctr.sv
// mem_ctr: memory-side responder on the cache/main-memory line bus (bus 2).
// It accepts whole-line read and write requests, holds the backing line
// storage, and answers each request with a single response after a fixed
// latency. For reads, the line is streamed back on D2.
//
// Ports
//   CLK      in     clock; all state updates on posedge
//   RESET    in     asynchronous active-low reset (FSM, counters, bus enables)
//   A2_WIRE  in     line address (tag + set)
//   D2_WIRE  inout  line data, one beat per cycle; [7:0] = lower byte address
//   C2_WIRE  inout  command from the initiator / response from this block
//
// State table
//   IDLE  | bus released, waiting for a READ_LINE or WRITE_LINE command
//   WR_RX | capturing the remaining write beats from D2
//   WAIT  | latency countdown before answering
//   RESP  | driving C2=RESPONSE for one cycle (write completion)
//   RD_TX | streaming the line on D2, RESPONSE with beat 0, NOP after

module mem_ctr #(
  parameter int ADDR2_BUS_SIZE  = 15,
  parameter int DATA_BUS_SIZE   = 16,
  parameter int CTR2_BUS_SIZE   = 2,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int MEM_CTR_DELAY   = 100
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [ADDR2_BUS_SIZE-1:0] A2_WIRE,
  inout  wire  [DATA_BUS_SIZE-1:0]  D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2_WIRE
);

  localparam int LINE_BEATS = CACHE_LINE_SIZE / (DATA_BUS_SIZE / 8);
  localparam int BEAT_W     = $clog2(LINE_BEATS);
  localparam int CNT_W      = $clog2(MEM_CTR_DELAY + 1);
  localparam int MEM_WORDS  = 2 ** (ADDR2_BUS_SIZE + BEAT_W);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  // A read starts counting right after the command edge. A write starts
  // counting only after its last beat, so the load value subtracts the
  // beats already spent; both then expire exactly at T0 + MEM_CTR_DELAY.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(MEM_CTR_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(MEM_CTR_DELAY - LINE_BEATS);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR_RX = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_RD_TX = 3'd4;

  // The latency must leave room for the full write burst plus one cycle.
  if (MEM_CTR_DELAY < LINE_BEATS + 1) begin : g_bad_delay
    $error("mem_ctr: MEM_CTR_DELAY must be at least LINE_BEATS+1");
  end

  logic [2:0]                state_q,  state_d;
  logic [ADDR2_BUS_SIZE-1:0] addr_q,   addr_d;
  logic [BEAT_W-1:0]         beat_q,   beat_d;
  logic [CNT_W-1:0]          cnt_q,    cnt_d;
  logic                      rd_q,     rd_d;
  logic                      d2_oe_q,  d2_oe_d;
  logic [DATA_BUS_SIZE-1:0]  d2_out_q, d2_out_d;
  logic                      c2_oe_q,  c2_oe_d;
  logic [CTR2_BUS_SIZE-1:0]  c2_out_q, c2_out_d;

  logic [DATA_BUS_SIZE-1:0]  line_mem [0:MEM_WORDS-1];

  logic [CTR2_BUS_SIZE-1:0]  c2_in;
  logic [DATA_BUS_SIZE-1:0]  d2_in;
  logic [BEAT_W-1:0]         beat_nxt;
  logic [BEAT_W-1:0]         rd_beat;
  logic [DATA_BUS_SIZE-1:0]  rd_word;
  logic                      accept;
  logic                      mem_we;
  logic [ADDR2_BUS_SIZE+BEAT_W-1:0] mem_widx;

  assign c2_in    = C2_WIRE;
  assign d2_in    = D2_WIRE;
  assign beat_nxt = beat_q + 1'b1;

  // Beat 0 is fetched while leaving WAIT; later beats while in RD_TX.
  assign rd_beat = (state_q == S_RD_TX) ? beat_nxt : '0;
  assign rd_word = line_mem[{addr_q, rd_beat}];

  assign D2_WIRE = d2_oe_q ? d2_out_q : 'z;
  assign C2_WIRE = c2_oe_q ? c2_out_q : 'z;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    d2_oe_d  = d2_oe_q;
    d2_out_d = d2_out_q;
    c2_oe_d  = c2_oe_q;
    c2_out_d = c2_out_q;
    mem_we   = 1'b0;
    mem_widx = {addr_q, beat_q};
    accept   = 1'b0;

    case (state_q)
      S_IDLE: accept = 1'b1;

      S_WR_RX: begin
        mem_we = 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = S_WAIT;
          cnt_d   = WR_LOAD;
        end else begin
          beat_d = beat_nxt;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          c2_oe_d  = 1'b1;
          c2_out_d = C2_RESPONSE;
          if (rd_q) begin
            state_d  = S_RD_TX;
            beat_d   = '0;
            d2_oe_d  = 1'b1;
            d2_out_d = rd_word;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RESP: begin
        c2_oe_d  = 1'b0;
        c2_out_d = C2_NOP;
        state_d  = S_IDLE;
        accept   = 1'b1;
      end

      S_RD_TX: begin
        if (beat_q == LAST_BEAT) begin
          d2_oe_d  = 1'b0;
          c2_oe_d  = 1'b0;
          c2_out_d = C2_NOP;
          state_d  = S_IDLE;
          accept   = 1'b1;
        end else begin
          beat_d   = beat_nxt;
          d2_out_d = rd_word;
          c2_out_d = C2_NOP;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The release edge of a response doubles as an IDLE edge so the next
    // request can be taken at the earliest legal posedge.
    if (accept) begin
      if (c2_in == C2_READ_LINE) begin
        addr_d  = A2_WIRE;
        rd_d    = 1'b1;
        cnt_d   = RD_LOAD;
        state_d = S_WAIT;
      end else if (c2_in == C2_WRITE_LINE) begin
        addr_d   = A2_WIRE;
        rd_d     = 1'b0;
        beat_d   = BEAT_W'(1);
        state_d  = S_WR_RX;
        mem_we   = 1'b1;
        mem_widx = {A2_WIRE, {BEAT_W{1'b0}}};
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      d2_oe_q  <= 1'b0;
      d2_out_q <= '0;
      c2_oe_q  <= 1'b0;
      c2_out_q <= C2_NOP;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      d2_oe_q  <= d2_oe_d;
      d2_out_q <= d2_out_d;
      c2_oe_q  <= c2_oe_d;
      c2_out_q <= c2_out_d;
    end
  end

  // Line storage survives reset; a write cut short by reset stays partial.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      line_mem[mem_widx] <= d2_in;
    end
  end

endmodule

// File: tb/tb_mem_ctr.sv
module tb_mem_ctr;

  localparam int A   = 15;
  localparam int DW  = 16;
  localparam int CW  = 2;
  localparam int LS  = 16;
  localparam int DLY = 100;
  localparam int LB  = LS / (DW / 8);
  localparam int LW  = LS * 8;

  localparam logic [CW-1:0] C2_NOP   = 2'd0;
  localparam logic [CW-1:0] C2_RESP  = 2'd1;
  localparam logic [CW-1:0] C2_READ  = 2'd2;
  localparam logic [CW-1:0] C2_WRITE = 2'd3;

  // Released-bus levels: D2 floats high, C2 floats low (reads as NOP).
  localparam logic [DW-1:0] D2_REL = '1;
  localparam logic [CW-1:0] C2_REL = '0;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [A-1:0]  a2;
  logic [DW-1:0] tb_d2;
  logic          tb_d2_oe;
  logic [CW-1:0] tb_c2;
  logic          tb_c2_oe;

  tri1 [DW-1:0] d2_bus;
  tri0 [CW-1:0] c2_bus;

  assign d2_bus = tb_d2_oe ? tb_d2 : 'z;
  assign c2_bus = tb_c2_oe ? tb_c2 : 'z;

  int checks = 0;
  int failures = 0;

  logic [LW-1:0] ref_line [logic [A-1:0]];

  always #5 CLK = ~CLK;

  mem_ctr #(
    .ADDR2_BUS_SIZE (A),
    .DATA_BUS_SIZE  (DW),
    .CTR2_BUS_SIZE  (CW),
    .CACHE_LINE_SIZE(LS),
    .MEM_CTR_DELAY  (DLY)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .A2_WIRE(a2),
    .D2_WIRE(d2_bus),
    .C2_WIRE(c2_bus)
  );

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    logic [DW-1:0] w;
    l = '0;
    for (int i = 0; i < LB; i++) begin
      w = DW'($urandom);
      while (w == D2_REL) w = DW'($urandom);
      l[i*DW +: DW] = w;
    end
    return l;
  endfunction

  // Called at a negedge; the command is sampled at the next posedge (T0).
  task automatic do_write(input logic [A-1:0] addr, input logic [LW-1:0] line);
    int c2_bad;
    int d2_bad;
    logic [CW-1:0] resp;
    c2_bad = 0;
    d2_bad = 0;
    resp = C2_REL;
    a2 = addr;
    tb_c2 = C2_WRITE;
    tb_c2_oe = 1'b1;
    tb_d2 = line[DW-1:0];
    tb_d2_oe = 1'b1;
    for (int k = 0; k <= DLY + 1; k++) begin
      @(negedge CLK);
      if (k >= 1) begin
        if (k == DLY) resp = c2_bus;
        else if (c2_bus !== C2_REL) c2_bad++;
        if (k >= LB && d2_bus !== D2_REL) d2_bad++;
      end
      if (k == 0) tb_c2_oe = 1'b0;
      if (k < LB - 1) tb_d2 = line[(k+1)*DW +: DW];
      else if (k == LB - 1) tb_d2_oe = 1'b0;
    end
    ref_line[addr] = line;
    checks++;
    if (resp !== C2_RESP) begin
      failures++;
      $display("FAIL wr_resp addr=%h got=%0d want=%0d", addr, resp, C2_RESP);
    end
    checks++;
    if (c2_bad !== 0) begin
      failures++;
      $display("FAIL wr_c2_window addr=%h bad_cycles=%0d want=0", addr, c2_bad);
    end
    checks++;
    if (d2_bad !== 0) begin
      failures++;
      $display("FAIL wr_d2_released addr=%h bad_cycles=%0d want=0", addr, d2_bad);
    end
  endtask

  // inject_k >= 0: push a WRITE_LINE to line 0 at cycle T0+inject_k.
  // abort_k >= 0: assert reset during cycle T0+abort_k and stop.
  task automatic do_read(input logic [A-1:0] addr, input int inject_k, input int abort_k);
    logic [LW-1:0] exp;
    int z_bad;
    int i;
    bit busy;
    exp = ref_line[addr];
    z_bad = 0;
    a2 = addr;
    tb_c2 = C2_READ;
    tb_c2_oe = 1'b1;
    for (int k = 0; k <= DLY + LB; k++) begin
      @(negedge CLK);
      if (k == 0) tb_c2_oe = 1'b0;
      busy = (inject_k >= 0) && (k > inject_k) && (k <= inject_k + LB);
      if (k >= 1 && !busy) begin
        if (k >= DLY && k < DLY + LB) begin
          i = k - DLY;
          checks++;
          if (d2_bus !== exp[i*DW +: DW] || c2_bus !== ((i == 0) ? C2_RESP : C2_NOP)) begin
            failures++;
            $display("FAIL rd_beat%0d addr=%h got d2=%h c2=%0d want d2=%h c2=%0d",
                     i, addr, d2_bus, c2_bus, exp[i*DW +: DW], (i == 0) ? C2_RESP : C2_NOP);
          end
        end else if (d2_bus !== D2_REL || c2_bus !== C2_REL) begin
          z_bad++;
        end
      end
      if (k == abort_k) begin
        RESET = 1'b0;
        #1;
        checks++;
        if (d2_bus !== D2_REL || c2_bus !== C2_REL) begin
          failures++;
          $display("FAIL reset_release got d2=%h c2=%0d want d2=%h c2=%0d",
                   d2_bus, c2_bus, D2_REL, C2_REL);
        end
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        return;
      end
      if (inject_k >= 0) begin
        if (k == inject_k) begin
          a2 = '0;
          tb_c2 = C2_WRITE;
          tb_c2_oe = 1'b1;
          tb_d2 = DW'($urandom);
          tb_d2_oe = 1'b1;
        end else if (k > inject_k && k < inject_k + LB) begin
          tb_c2_oe = 1'b0;
          tb_d2 = DW'($urandom);
        end else if (k == inject_k + LB) begin
          tb_d2_oe = 1'b0;
        end
      end
    end
    checks++;
    if (z_bad !== 0) begin
      failures++;
      $display("FAIL rd_outside_window addr=%h bad_cycles=%0d want=0", addr, z_bad);
    end
  endtask

  task automatic test_reset();
    int bad;
    a2 = '0;
    tb_c2 = C2_NOP;
    tb_c2_oe = 1'b0;
    tb_d2 = '0;
    tb_d2_oe = 1'b0;
    #1 RESET = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (d2_bus !== D2_REL) begin
      failures++;
      $display("FAIL reset_d2 got=%h want=%h", d2_bus, D2_REL);
    end
    checks++;
    if (c2_bus !== C2_REL) begin
      failures++;
      $display("FAIL reset_c2 got=%0d want=%0d", c2_bus, C2_REL);
    end
    RESET = 1'b1;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (d2_bus !== D2_REL || c2_bus !== C2_REL) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle bad_cycles=%0d want=0", bad);
    end
  endtask

  task automatic test_write_read();
    logic [LW-1:0] l;
    l = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    do_write(15'h0123, l);
    do_read(15'h0123, -1, -1);
  endtask

  task automatic test_busy();
    do_write(15'h7FFF, rand_line());
    do_write(15'h0000, rand_line());
    do_read(15'h7FFF, 20, -1);
    do_read(15'h0000, -1, -1);
  endtask

  task automatic test_reset_mid_read();
    do_read(15'h0123, -1, DLY + 3);
    do_read(15'h0123, -1, -1);
  endtask

  task automatic test_back_to_back();
    do_write(15'h7FFF, rand_line());
    do_read(15'h7FFF, -1, -1);
  endtask

  task automatic test_random();
    logic [A-1:0] addrs [4];
    for (int n = 0; n < 4; n++) begin
      addrs[n] = A'($urandom);
      do_write(addrs[n], rand_line());
    end
    for (int n = 3; n >= 0; n--) begin
      do_read(addrs[n], -1, -1);
    end
    do_read(15'h0123, -1, -1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_busy();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
